// File: rtl/uart_tx.sv
// uart_tx: byte-wide UART serial transmitter.
// Frame = start bit (0), BYTE data bits LSB first, STOP_BITS stop bits (1).
// A one-entry holding register decouples the valid/ready handshake from the
// shifter, so a byte accepted during a frame follows it with no idle gap.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | line high, waiting for the holding register to fill
//   START | line low for one bit period
//   DATA  | shifting out data bits, one bit period each, LSB first
//   STOP  | line high for STOP_BITS bit periods, then reload or idle
module uart_tx #(
  parameter int CLK_FRQ   = 250000000,
  parameter int BAUD_RATE = 115200,
  parameter int BYTE      = 8,
  parameter int STOP_BITS = 1
) (
  input  logic            clk,
  input  logic            areset_n,
  input  logic            tx_valid,
  input  logic [BYTE-1:0] tx_data,
  output logic            tx_ready,
  output logic            data_out,
  output logic            tx_busy,
  output logic            tx_done
);

  localparam int BAUD_DIV = CLK_FRQ / BAUD_RATE;
  localparam int CNT_W    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam int IDX_W    = (BYTE > 1) ? $clog2(BYTE) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BAUD_DIV - 1);
  // One cycle before the end of a bit: used to place tx_done inside the
  // final stop cycle, so the pulse is seen before the line is released.
  localparam logic [CNT_W-1:0] CNT_PRE   = CNT_W'(BAUD_DIV - 2);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(BYTE - 1);
  localparam logic             STOP_LAST = (STOP_BITS == 2);

  if (BAUD_DIV < 2) begin : g_baud_check
    $error("uart_tx: BAUD_DIV = CLK_FRQ/BAUD_RATE must be at least 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_stop_check
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end
  if (BYTE < 1) begin : g_byte_check
    $error("uart_tx: BYTE must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic            stop_idx;
  logic [BYTE-1:0] shifter;
  logic [BYTE-1:0] shift_nxt;
  logic [BYTE-1:0] hold;
  logic            hold_full;
  logic            bit_end;
  logic            stop_last;
  logic            start_frame;

  // Bit-period boundary and next data bit for the shifter.
  assign bit_end   = (cnt == CNT_LAST);
  assign stop_last = (stop_idx == STOP_LAST);
  assign shift_nxt = shifter >> 1;

  // A new frame begins from IDLE, or directly at the end of the last stop
  // bit, whenever the holding register has a byte waiting.
  assign start_frame = hold_full &&
                       ((state == IDLE) ||
                        (state == STOP && bit_end && stop_last));

  // Handshake, holding register and frame sequencing with registered outputs.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      stop_idx  <= 1'b0;
      shifter   <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      tx_ready  <= 1'b1;
      data_out  <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      tx_done <= 1'b0;

      if (tx_valid && tx_ready) begin
        hold      <= tx_data;
        hold_full <= 1'b1;
        tx_ready  <= 1'b0;
      end

      case (state)
        IDLE: begin
          data_out <= 1'b1;
          tx_busy  <= 1'b0;
        end

        START: begin
          if (bit_end) begin
            cnt      <= '0;
            idx      <= '0;
            state    <= DATA;
            data_out <= shifter[0];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (idx == IDX_LAST) begin
              state    <= STOP;
              stop_idx <= 1'b0;
              data_out <= 1'b1;
            end else begin
              idx      <= idx + 1'b1;
              shifter  <= shift_nxt;
              data_out <= shift_nxt[0];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        STOP: begin
          if (stop_last && cnt == CNT_PRE) begin
            tx_done <= 1'b1;
          end
          if (bit_end) begin
            cnt <= '0;
            if (stop_last) begin
              state   <= IDLE;
              tx_busy <= 1'b0;
            end else begin
              stop_idx <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          data_out <= 1'b1;
          tx_busy  <= 1'b0;
        end
      endcase

      // Reload overrides the IDLE / end-of-stop decisions above.
      if (start_frame) begin
        shifter   <= hold;
        hold_full <= 1'b0;
        tx_ready  <= 1'b1;
        state     <= START;
        data_out  <= 1'b0;
        cnt       <= '0;
        tx_busy   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx with BAUD_DIV=8, BYTE=8, run
// against one instance with one stop bit and one with two stop bits.
module tb_uart_tx;

  localparam int BD = 8;

  typedef struct {
    logic [7:0] data;
    int         start;
  } exp_t;

  logic clk;
  int   cyc;
  int   vectors;
  int   miscompares;
  bit   stim_done [2];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Expected line level at offset j cycles into a frame.
  function automatic logic line_exp(input logic [7:0] d, input int j);
    if (j < BD) return 1'b0;
    if (j < 9 * BD) return d[(j - BD) / BD];
    return 1'b1;
  endfunction

  for (genvar m = 0; m < 2; m++) begin : g_inst
    localparam int SB    = m + 1;
    localparam int FRAME = (1 + 8 + SB) * BD;

    logic       areset_n;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       data_out;
    logic       tx_busy;
    logic       tx_done;

    exp_t q[$];
    int   hold_release;
    int   last_end;
    int   idle_err;

    uart_tx #(
      .CLK_FRQ  (8),
      .BAUD_RATE(1),
      .BYTE     (8),
      .STOP_BITS(SB)
    ) dut (
      .clk     (clk),
      .areset_n(areset_n),
      .tx_valid(tx_valid),
      .tx_data (tx_data),
      .tx_ready(tx_ready),
      .data_out(data_out),
      .tx_busy (tx_busy),
      .tx_done (tx_done)
    );

    // One stimulus cycle: check tx_ready against the model, drive inputs for
    // the next edge, and schedule the frame of any predicted transfer.
    task automatic step(input logic v, input logic [7:0] d, output bit acc);
      int n;
      int a;
      int s;
      exp_t e;
      @(negedge clk);
      n = cyc;
      chk($sformatf("tx_ready sb=%0d", SB), int'(tx_ready), int'(n >= hold_release));
      tx_valid = v;
      tx_data  = d;
      acc = v && (n >= hold_release);
      if (acc) begin
        a = n + 1;
        s = (a + 1 > last_end) ? a + 1 : last_end;
        e.data  = d;
        e.start = s;
        q.push_back(e);
        hold_release = s;
        last_end     = s + FRAME;
      end
    endtask

    task automatic idle(input int cycles);
      bit acc;
      for (int i = 0; i < cycles; i++) step(1'b0, 8'h00, acc);
    endtask

    task automatic send_hold(input logic [7:0] d);
      bit acc;
      int k;
      k = 0;
      do begin
        step(1'b1, d, acc);
        k++;
      end while (!acc && k < 1000);
      if (!acc) chk($sformatf("accept_timeout sb=%0d", SB), 0, 1);
    endtask

    // Stimulus.
    initial begin
      bit acc;
      int s;
      int k;
      areset_n     = 1'b0;
      tx_valid     = 1'b0;
      tx_data      = 8'h00;
      hold_release = 0;
      last_end     = 0;
      idle_err     = 0;
      @(negedge clk);
      chk($sformatf("reset data_out sb=%0d", SB), int'(data_out), 1);
      chk($sformatf("reset tx_ready sb=%0d", SB), int'(tx_ready), 1);
      chk($sformatf("reset tx_busy sb=%0d", SB), int'(tx_busy), 0);
      chk($sformatf("reset tx_done sb=%0d", SB), int'(tx_done), 0);
      @(negedge clk);
      areset_n = 1'b1;
      idle(5);

      send_hold(8'hA5);
      idle(FRAME + 10);

      send_hold(8'h00);
      send_hold(8'hFF);
      send_hold(8'h3C);
      idle(4 * FRAME);

      for (int i = 0; i < 1500; i++) begin
        step(($urandom_range(0, 9) < 3), 8'($urandom), acc);
      end
      idle(3 * FRAME);

      // Asynchronous reset in the middle of data bit 3 of an all-zero byte.
      send_hold(8'h00);
      s = hold_release;
      while (cyc < s + BD + 3 * BD + 4) step(1'b0, 8'h00, acc);
      chk($sformatf("bit3 level before reset sb=%0d", SB), int'(data_out), 0);
      @(posedge clk);
      #2;
      areset_n = 1'b0;
      #1;
      chk($sformatf("async reset data_out sb=%0d", SB), int'(data_out), 1);
      chk($sformatf("async reset tx_ready sb=%0d", SB), int'(tx_ready), 1);
      chk($sformatf("async reset tx_busy sb=%0d", SB), int'(tx_busy), 0);
      q.delete();
      hold_release = 0;
      last_end     = 0;
      repeat (3) @(negedge clk);
      areset_n = 1'b1;
      idle(150);

      send_hold(8'($urandom));
      idle(FRAME + 20);

      k = 0;
      while (q.size() != 0 && k < 5000) begin
        @(negedge clk);
        k++;
      end
      chk($sformatf("drain queue_left sb=%0d", SB), q.size(), 0);
      chk($sformatf("idle busy/done errors sb=%0d", SB), idle_err, 0);
      stim_done[m] = 1'b1;
    end

    // Monitor: decode each frame on the line and compare with the scoreboard.
    initial begin
      exp_t e;
      int   n;
      int   mism;
      int   dones;
      int   done_pos;
      bit   aborted;
      logic [7:0] decoded;
      forever begin
        @(negedge clk);
        if (!areset_n) continue;
        if (data_out == 1'b0) begin
          n = cyc;
          if (q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_frame sb=%0d: actual=start at cycle %0d required=no frame", SB, n);
            continue;
          end
          e = q.pop_front();
          chk($sformatf("frame start cycle sb=%0d", SB), n, e.start);
          mism     = 0;
          dones    = 0;
          done_pos = -1;
          aborted  = 1'b0;
          decoded  = 8'h00;
          for (int j = 0; j < FRAME; j++) begin
            if (j > 0) @(negedge clk);
            if (!areset_n) begin
              aborted = 1'b1;
              break;
            end
            if (data_out !== line_exp(e.data, j)) mism++;
            if (tx_busy !== 1'b1) mism++;
            if (tx_done === 1'b1) begin
              dones++;
              done_pos = j;
            end
            if (j >= BD && j < 9 * BD && ((j - BD) % BD) == BD / 2)
              decoded[(j - BD) / BD] = data_out;
          end
          if (!aborted) begin
            chk($sformatf("line/busy sample errors sb=%0d", SB), mism, 0);
            chk($sformatf("decoded byte sb=%0d", SB), int'(decoded), int'(e.data));
            chk($sformatf("tx_done pulse count sb=%0d", SB), dones, 1);
            chk($sformatf("tx_done offset sb=%0d", SB), done_pos, FRAME - 1);
          end
        end else begin
          if (tx_busy !== 1'b0 || tx_done !== 1'b0) idle_err++;
        end
      end
    end
  end

  initial begin
    int k;
    vectors     = 0;
    miscompares = 0;
    k = 0;
    while (!(stim_done[0] && stim_done[1]) && k < 40000) begin
      @(posedge clk);
      k++;
    end
    if (!(stim_done[0] && stim_done[1])) begin
      vectors++;
      miscompares++;
      $display("FAIL global_timeout: actual=stimulus unfinished required=finished");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
